// File: rtl/data_mem_responder_pkg.sv
// Package: data_mem_responder_pkg
// Purpose: shared types and helpers for the data memory responder.
//   - state_t      : responder FSM states (idle, waiting out latency, responding)
//   - kind_t       : kind of the latched request (read or write)
//   - MEM_W_*      : write width codes in bytes (0 = no-op write)
//   - be_from      : byte-lane enables for a write of a given width at a byte offset
//   - is_misaligned: true when a write width/offset pair cannot be committed
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } kind_t;

    localparam logic [2:0] MEM_W_NONE = 3'd0;
    localparam logic [2:0] MEM_W_B    = 3'd1;
    localparam logic [2:0] MEM_W_H    = 3'd2;
    localparam logic [2:0] MEM_W_W    = 3'd4;

    // Lanes are little-endian: lane 0 holds the byte at offset 0.
    function automatic logic [3:0] be_from(input logic [2:0] width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            MEM_W_B: be = 4'b0001 << off;
            MEM_W_H: be = 4'b0011 << off;
            MEM_W_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Unknown width codes are reported as misaligned so they never touch RAM.
    function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] off);
        logic bad;
        case (width)
            MEM_W_NONE: bad = 1'b0;
            MEM_W_B:    bad = 1'b0;
            MEM_W_H:    bad = off[0];
            MEM_W_W:    bad = (off != 2'd0);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Interface: data_mem_responder_if
// Purpose: load/store port between the execute stage (master) and the
//   data memory responder (slave).
// Signals:
//   addr      master->slave  byte address, held while a request is pending
//   wr_data   master->slave  write data, right-aligned
//   wr_valid  master->slave  write request
//   wr_width  master->slave  write width in bytes (1, 2, 4; 0 = no-op)
//   rd_ready  master->slave  read request
//   wr_ready  slave->master  write acknowledge pulse
//   rd_valid  slave->master  read data valid pulse
//   rd_data   slave->master  read word shifted right by the byte offset
//   err       slave->master  qualifies the current pulse as misaligned
interface data_mem_responder_if;

    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic [2:0]  wr_width;
    logic        rd_ready;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;

    modport master (
        output addr, wr_data, wr_valid, wr_width, rd_ready,
        input  wr_ready, rd_valid, rd_data, err
    );

    modport slave (
        input  addr, wr_data, wr_valid, wr_width, rd_ready,
        output wr_ready, rd_valid, rd_data, err
    );

endinterface

// File: rtl/data_mem_responder_bram.sv
// Module: data_mem_responder_bram
// Purpose: single-port synchronous word RAM with four byte-lane write enables.
//   Reads are registered; contents are never reset.
// Ports:
//   clk    clock
//   re     read enable; rdata is updated on the next clock edge
//   be     byte-lane write enables (lane 0 = bits 7:0)
//   index  word index
//   wdata  write data, already placed in its byte lanes
//   rdata  registered read word
module data_mem_responder_bram #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    AW          = $clog2(DEPTH_WORDS),
    parameter string INIT_FILE   = ""
) (
    input  logic          clk,
    input  logic          re,
    input  logic [3:0]    be,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (be[lane]) begin
                mem[index][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
        if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Module: data_mem_responder
// Purpose: memory-side responder for the execute stage's load/store port.
//   Accepts one read or write request at a time, waits a configurable number
//   of cycles, then returns a one-cycle acknowledge (write) or data-valid
//   (read) pulse. Writes commit on the acknowledge edge; reads return the
//   addressed word shifted right by the byte offset, zero-filled.
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   load/store port (slave side of data_mem_responder_if)
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    RD_LATENCY  = 1,
    parameter int    WR_LATENCY  = 0,
    parameter string INIT_FILE   = ""
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);

    state_t          state;
    state_t          state_next;
    kind_t           kind;
    logic [3:0]      cnt;
    logic [AW-1:0]   lat_index;
    logic [1:0]      lat_off;
    logic [31:0]     lat_data;
    logic [2:0]      lat_width;

    logic            accept_wr;
    logic            accept_rd;
    logic            cnt_dec;
    logic            ram_re;
    logic            resp_fire;
    logic            req_live;
    logic            wr_bad;
    logic [3:0]      ram_be;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_q;

    // Address bits above the RAM index are ignored, so the RAM wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:AW+2];

    // The request that started the transaction must stay asserted during WAIT.
    assign req_live  = (kind == KIND_WR) ? bus.wr_valid : bus.rd_ready;
    assign wr_bad    = is_misaligned(lat_width, lat_off);
    assign ram_wdata = lat_data << {lat_off, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        cnt_dec    = 1'b0;
        ram_re     = 1'b0;
        resp_fire  = 1'b0;
        ram_be     = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (bus.wr_valid) begin
                    accept_wr  = 1'b1;
                    state_next = ST_WAIT;
                end else if (bus.rd_ready) begin
                    accept_rd  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req_live) begin
                    state_next = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    // The RAM's registered output holds this word throughout RESP.
                    ram_re     = (kind == KIND_RD);
                    state_next = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                resp_fire  = 1'b1;
                state_next = ST_IDLE;
                // The write commits on the same edge that raises the acknowledge.
                if (kind == KIND_WR && !wr_bad) begin
                    ram_be = be_from(lat_width, lat_off);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, latency counter and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind         <= KIND_RD;
            cnt          <= 4'd0;
            lat_index    <= '0;
            lat_off      <= 2'd0;
            lat_data     <= 32'd0;
            lat_width    <= MEM_W_NONE;
            bus.wr_ready <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.err      <= 1'b0;
            bus.rd_data  <= 32'd0;
        end else begin
            if (accept_wr || accept_rd) begin
                kind      <= accept_wr ? KIND_WR : KIND_RD;
                cnt       <= accept_wr ? WR_LAT : RD_LAT;
                lat_index <= bus.addr[AW+1:2];
                lat_off   <= bus.addr[1:0];
                lat_data  <= bus.wr_data;
                lat_width <= bus.wr_width;
            end else if (cnt_dec) begin
                cnt <= cnt - 4'd1;
            end
            bus.wr_ready <= resp_fire && (kind == KIND_WR);
            bus.rd_valid <= resp_fire && (kind == KIND_RD);
            bus.err      <= resp_fire && (kind == KIND_WR) && wr_bad;
            if (resp_fire && kind == KIND_RD) begin
                bus.rd_data <= ram_q >> {lat_off, 3'b000};
            end
        end
    end

    data_mem_responder_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_bram (
        .clk   (clk),
        .re    (ram_re),
        .be    (ram_be),
        .index (lat_index),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

endmodule
